// File: rtl/updown_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// updown_ctrl_pkg
// Shared definitions for the up/down counter sequencer:
//   - command opcode encodings carried on cmd_op
//   - counting direction encodings held in the latched command
//   - FSM state type used by the top-level sequencer
// -----------------------------------------------------------------------------
package updown_ctrl_pkg;

  // Command opcodes (cmd_op)
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Counting direction as seen by the counter core
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // True for opcodes that step the counter (UP/DOWN)
  function automatic logic is_step_op(input logic [1:0] op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/updown_count_ctrl_if.sv
// -----------------------------------------------------------------------------
// updown_count_ctrl_if
// Command channel of the up/down counter sequencer (valid/ready handshake).
//   cmd_valid  master -> slave  command present
//   cmd_ready  slave  -> master sequencer can accept this cycle
//   cmd_op     master -> slave  LOAD / UP / DOWN / CLEAR
//   cmd_steps  master -> slave  number of steps for UP/DOWN
//   cmd_data   master -> slave  load value for LOAD
//   sat_en     master -> slave  1 = saturate, 0 = wrap (sampled at accept)
// -----------------------------------------------------------------------------
interface updown_count_ctrl_if #(
  parameter int WIDTH   = 4,
  parameter int STEPS_W = 8
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [STEPS_W-1:0] cmd_steps;
  logic [WIDTH-1:0]   cmd_data;
  logic               sat_en;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_steps,
    output cmd_data,
    output sat_en,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_steps,
    input  cmd_data,
    input  sat_en,
    output cmd_ready
  );

endinterface

// File: rtl/updown_counter_core.sv
// -----------------------------------------------------------------------------
// updown_counter_core
// Fully synchronous WIDTH-bit up/down counter with load, wrap or saturate.
//   clk       in   clock, all bits change on the rising edge
//   rst       in   asynchronous active-low reset (count = 0, ovf = 0)
//   en        in   perform one step this edge
//   dir       in   0 = up, 1 = down
//   load      in   load load_val this edge (takes priority over en)
//   load_val  in   value loaded when load is high
//   sat       in   1 = hold at the limit, 0 = wrap around
//   count     out  registered counter value
//   ovf       out  registered pulse accompanying a step taken at the limit
// -----------------------------------------------------------------------------
module updown_counter_core
  import updown_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             ovf_reg;
  logic             ovf_next;
  logic             at_limit;
  logic [WIDTH-1:0] stepped;

  // The limit depends on direction: max going up, zero going down.
  assign at_limit = (dir == DIR_DOWN) ? (count_reg == '0) : (count_reg == MAX_VAL);
  assign stepped  = (dir == DIR_DOWN) ? (count_reg - 1'b1) : (count_reg + 1'b1);

  always_comb begin
    count_next = count_reg;
    ovf_next   = 1'b0;
    if (load) begin
      count_next = load_val;
    end else if (en) begin
      // A step at the limit always flags ovf; in saturate mode the value
      // is simply left where it is, the modulo arithmetic handles wrap.
      ovf_next = at_limit;
      if (!(at_limit && sat)) begin
        count_next = stepped;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign count = count_reg;
  assign ovf   = ovf_reg;

endmodule

// File: rtl/updown_count_ctrl.sv
// -----------------------------------------------------------------------------
// updown_count_ctrl
// Command-driven sequencer for a WIDTH-bit up/down counter. Commands arrive
// over a valid/ready channel; UP/DOWN commands step the counter core exactly
// cmd_steps times, one step per clock, honouring hold and abort.
//   clk    in   single clock
//   rst    in   asynchronous active-low reset
//   cmd    --   command channel (slave side): valid/ready, op, steps, data, sat_en
//   hold   in   freeze stepping while high (RUN only)
//   abort  in   end the current UP/DOWN command (RUN only, beats hold)
//   count  out  registered counter value
//   busy   out  high whenever the sequencer is not IDLE
//   done   out  one-cycle pulse when a command completes
//   ovf    out  one-cycle pulse with the step that wrapped or saturated
// -----------------------------------------------------------------------------
module updown_count_ctrl
  import updown_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int STEPS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  updown_count_ctrl_if.slave cmd,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  state_e             state_reg;
  state_e             state_next;
  logic [STEPS_W-1:0] remaining_reg;
  logic [STEPS_W-1:0] remaining_next;
  logic               dir_reg;
  logic               dir_next;
  logic               sat_reg;
  logic               sat_next;

  logic               ready;
  logic               accept;
  logic               core_en;
  logic               core_load;
  logic [WIDTH-1:0]   core_load_val;

  // Ready is gated by rst so nothing is taken while reset is held.
  assign ready         = (state_reg == IDLE) && rst;
  assign cmd.cmd_ready = ready;
  assign accept        = cmd.cmd_valid && ready;

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    dir_next       = dir_reg;
    sat_next       = sat_reg;
    core_en        = 1'b0;
    core_load      = 1'b0;
    core_load_val  = '0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (cmd.cmd_op == OP_LOAD) begin
            core_load     = 1'b1;
            core_load_val = cmd.cmd_data;
            state_next    = DONE;
          end else if (cmd.cmd_op == OP_CLEAR) begin
            core_load     = 1'b1;
            core_load_val = '0;
            state_next    = DONE;
          end else if (is_step_op(cmd.cmd_op) && (cmd.cmd_steps != '0)) begin
            remaining_next = cmd.cmd_steps;
            dir_next       = (cmd.cmd_op == OP_DOWN) ? DIR_DOWN : DIR_UP;
            sat_next       = cmd.sat_en;
            state_next     = RUN;
          end else begin
            // Zero-step UP/DOWN completes without touching the counter.
            state_next = DONE;
          end
        end
      end

      RUN: begin
        if (abort) begin
          remaining_next = '0;
          state_next     = DONE;
        end else if (!hold) begin
          core_en        = 1'b1;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == {{(STEPS_W-1){1'b0}}, 1'b1}) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      dir_reg       <= DIR_UP;
      sat_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      dir_reg       <= dir_next;
      sat_reg       <= sat_next;
    end
  end

  updown_counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (core_en),
    .dir      (dir_reg),
    .load     (core_load),
    .load_val (core_load_val),
    .sat      (sat_reg),
    .count    (count),
    .ovf      (ovf)
  );

  // Both flags come straight from the state register, so command inputs
  // never reach them combinationally.
  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_updown_count_ctrl.sv
// -----------------------------------------------------------------------------
// tb_updown_count_ctrl
// Directed self-checking bench for updown_count_ctrl. Inputs change and
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_updown_count_ctrl;
  import updown_ctrl_pkg::*;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       hold  = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  updown_count_ctrl_if #(.WIDTH(4), .STEPS_W(8)) cmd_if ();

  updown_count_ctrl #(
    .WIDTH   (4),
    .STEPS_W (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .cmd   (cmd_if),
    .hold  (hold),
    .abort (abort),
    .count (count),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Called at a falling edge; presents a command, lets it be accepted on the
  // next rising edge, and returns at the following falling edge (cycle 1).
  task automatic send(input logic [1:0] op, input int steps, input logic [3:0] data,
                      input logic sat, input string tag);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_steps = steps[7:0];
    cmd_if.cmd_data  = data;
    cmd_if.sat_en    = sat;
    check_eq({tag, "/ready"}, {31'd0, cmd_if.cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Advance one edge and check count / ovf / done.
  task automatic step_chk(input string tag, input logic [3:0] ec, input logic eo, input logic ed);
    @(negedge clk);
    check_eq({tag, "/count"}, {28'd0, count}, {28'd0, ec});
    check_eq({tag, "/ovf"},   {31'd0, ovf},   {31'd0, eo});
    check_eq({tag, "/done"},  {31'd0, done},  {31'd0, ed});
  endtask

  // Advance one edge and check the sequencer is back in IDLE.
  task automatic idle_chk(input string tag);
    @(negedge clk);
    check_eq({tag, "/idle_done"},  {31'd0, done},             32'd0);
    check_eq({tag, "/idle_busy"},  {31'd0, busy},             32'd0);
    check_eq({tag, "/idle_ready"}, {31'd0, cmd_if.cmd_ready}, 32'd1);
  endtask

  // Check the cycle right after a LOAD/CLEAR/zero-step accept.
  task automatic single_chk(input string tag, input logic [3:0] ec);
    check_eq({tag, "/count"}, {28'd0, count}, {28'd0, ec});
    check_eq({tag, "/done"},  {31'd0, done},  32'd1);
    check_eq({tag, "/busy"},  {31'd0, busy},  32'd1);
    idle_chk(tag);
  endtask

  initial begin
    #100000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_steps = '0;
    cmd_if.cmd_data  = '0;
    cmd_if.sat_en    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst/count", {28'd0, count},            32'd0);
    check_eq("rst/busy",  {31'd0, busy},             32'd0);
    check_eq("rst/done",  {31'd0, done},             32'd0);
    check_eq("rst/ovf",   {31'd0, ovf},              32'd0);
    check_eq("rst/ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check_eq("rst/ready_release", {31'd0, cmd_if.cmd_ready}, 32'd1);
    @(negedge clk);

    // LOAD 9
    send(OP_LOAD, 0, 4'h9, 1'b0, "load9");
    single_chk("load9", 4'h9);

    // CLEAR then UP 5
    send(OP_CLEAR, 0, 4'h7, 1'b0, "clear");
    single_chk("clear", 4'h0);
    send(OP_UP, 5, 4'h0, 1'b0, "up5");
    check_eq("up5/c1_count", {28'd0, count},            32'd0);
    check_eq("up5/c1_busy",  {31'd0, busy},             32'd1);
    check_eq("up5/c1_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    for (int k = 1; k <= 5; k++) step_chk("up5", k[3:0], 1'b0, (k == 5));
    idle_chk("up5");

    // Zero-step UP: count unchanged, immediate done
    send(OP_UP, 0, 4'h0, 1'b0, "up0");
    single_chk("up0", 4'h5);

    // Wrap mode: 14 -> 15, 0 (ovf), 1
    send(OP_LOAD, 0, 4'he, 1'b0, "load14w");
    single_chk("load14w", 4'he);
    send(OP_UP, 3, 4'h0, 1'b0, "up3wrap");
    step_chk("up3wrap_s1", 4'hf, 1'b0, 1'b0);
    step_chk("up3wrap_s2", 4'h0, 1'b1, 1'b0);
    step_chk("up3wrap_s3", 4'h1, 1'b0, 1'b1);
    idle_chk("up3wrap");

    // Saturate mode: 14 -> 15, 15 (ovf), 15 (ovf)
    send(OP_LOAD, 0, 4'he, 1'b0, "load14s");
    single_chk("load14s", 4'he);
    send(OP_UP, 3, 4'h0, 1'b1, "up3sat");
    step_chk("up3sat_s1", 4'hf, 1'b0, 1'b0);
    step_chk("up3sat_s2", 4'hf, 1'b1, 1'b0);
    step_chk("up3sat_s3", 4'hf, 1'b1, 1'b1);
    idle_chk("up3sat");

    // Saturate at zero going down
    send(OP_LOAD, 0, 4'h1, 1'b0, "load1s");
    single_chk("load1s", 4'h1);
    send(OP_DOWN, 2, 4'h0, 1'b1, "dn2sat");
    step_chk("dn2sat_s1", 4'h0, 1'b0, 1'b0);
    step_chk("dn2sat_s2", 4'h0, 1'b1, 1'b1);
    idle_chk("dn2sat");

    // DOWN 4 from 1 with two hold cycles after the first step
    send(OP_LOAD, 0, 4'h1, 1'b0, "load1h");
    single_chk("load1h", 4'h1);
    send(OP_DOWN, 4, 4'h0, 1'b0, "dn4hold");
    step_chk("dn4hold_s1", 4'h0, 1'b0, 1'b0);
    hold = 1'b1;
    step_chk("dn4hold_h1", 4'h0, 1'b0, 1'b0);
    check_eq("dn4hold_h1/busy", {31'd0, busy}, 32'd1);
    step_chk("dn4hold_h2", 4'h0, 1'b0, 1'b0);
    hold = 1'b0;
    step_chk("dn4hold_s2", 4'hf, 1'b1, 1'b0);
    step_chk("dn4hold_s3", 4'he, 1'b0, 1'b0);
    step_chk("dn4hold_s4", 4'hd, 1'b0, 1'b1);
    idle_chk("dn4hold");

    // Abort after the third step
    send(OP_CLEAR, 0, 4'h0, 1'b0, "clear_ab");
    single_chk("clear_ab", 4'h0);
    send(OP_UP, 10, 4'h0, 1'b0, "up10ab");
    step_chk("up10ab_s1", 4'h1, 1'b0, 1'b0);
    step_chk("up10ab_s2", 4'h2, 1'b0, 1'b0);
    step_chk("up10ab_s3", 4'h3, 1'b0, 1'b0);
    abort = 1'b1;
    step_chk("up10ab_abort", 4'h3, 1'b0, 1'b1);
    abort = 1'b0;
    idle_chk("up10ab");

    // Hold and abort together: abort wins
    send(OP_UP, 10, 4'h0, 1'b0, "up10ha");
    step_chk("up10ha_s1", 4'h4, 1'b0, 1'b0);
    step_chk("up10ha_s2", 4'h5, 1'b0, 1'b0);
    hold  = 1'b1;
    abort = 1'b1;
    step_chk("up10ha_abort", 4'h5, 1'b0, 1'b1);
    hold  = 1'b0;
    idle_chk("up10ha");

    // Abort is ignored outside RUN: LOAD still completes normally
    send(OP_LOAD, 0, 4'h2, 1'b0, "load2ab");
    single_chk("load2ab", 4'h2);
    abort = 1'b0;

    // Reset in the middle of RUN, with a command held valid across reset
    send(OP_CLEAR, 0, 4'h0, 1'b0, "clear_rst");
    single_chk("clear_rst", 4'h0);
    send(OP_UP, 10, 4'h0, 1'b0, "up10rst");
    for (int k = 1; k <= 6; k++) step_chk("up10rst", k[3:0], 1'b0, 1'b0);
    rst              = 1'b0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_data  = 4'h5;
    #1;
    check_eq("midrst/count", {28'd0, count},            32'd0);
    check_eq("midrst/busy",  {31'd0, busy},             32'd0);
    check_eq("midrst/ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq("midrst/hold_count", {28'd0, count}, 32'd0);
      check_eq("midrst/hold_done",  {31'd0, done},  32'd0);
    end
    rst = 1'b1;
    #1;
    check_eq("midrst/ready_release", {31'd0, cmd_if.cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    single_chk("postrst_load5", 4'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
